// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, the default
// bubble encoding and the fetch state encoding.
package fetch_stage_pkg;

  localparam logic [4:0]  OP_HALT          = 5'b00000;
  localparam logic [4:0]  OP_NOP           = 5'b00001;
  localparam logic [15:0] NOP_DEFAULT      = {OP_NOP, 11'b000_0000_0000};
  localparam int unsigned MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetchState_t;

  function automatic logic isHalt(input logic [15:0] instr);
    return (instr[15:11] == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and a variable-latency instruction memory (slave).
interface fetch_stage_if;

  logic        imemEn;
  logic [15:0] imemAddr;
  logic        imemDone;
  logic [15:0] imemData;
  logic        imemErr;

  modport master (
    output imemEn,
    output imemAddr,
    input  imemDone,
    input  imemData,
    input  imemErr
  );

  modport slave (
    input  imemEn,
    input  imemAddr,
    output imemDone,
    output imemData,
    output imemErr
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction and its PC+2, used when a
// response arrives while decode is stalled.
module fetch_skid_buf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             pop,
  input  logic [WIDTH-1:0] instrIn,
  input  logic [WIDTH-1:0] pcIn,
  output logic             full,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc
);

  // Entry state: clear wins over load, load over pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full  <= 1'b0;
      instr <= {WIDTH{1'b0}};
      pc    <= {WIDTH{1'b0}};
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= instrIn;
      pc    <= pcIn;
    end else if (pop) begin
      full <= 1'b0;
    end else begin
      full <= full;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency
// instruction memory and feeds the decode pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_DEFAULT,
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [15:0]   redirectPc,
  fetch_stage_if.master imem,
  output logic [15:0]   instrOut,
  output logic [15:0]   nextPcOut,
  output logic          validOut,
  output logic          halted,
  output logic          err
);

  localparam int unsigned      CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  fetchState_t      state;
  logic [15:0]      pc;
  logic             discard;
  logic [CNT_W-1:0] waitCnt;

  logic             skidFull;
  logic [15:0]      skidInstr;
  logic [15:0]      skidPc;

  logic [15:0]      pcPlus2;
  logic             respValid;
  logic             freshResp;
  logic             skidLoad;
  logic             skidPop;
  logic             errSet;

  assign pcPlus2   = pc + 16'd2;
  assign respValid = (state == ST_WAIT) && imem.imemDone;
  // A response is usable only if it is not the stale one behind a redirect.
  assign freshResp = respValid && !discard && !redirect;
  assign skidLoad  = freshResp && stall;
  assign skidPop   = skidFull && !stall && !redirect;
  assign errSet    = (redirect && redirectPc[0])
                   || (respValid && imem.imemErr)
                   || ((state == ST_WAIT) && !imem.imemDone && (waitCnt == CNT_LAST));

  fetch_skid_buf #(
    .WIDTH (16)
  ) skidBuf (
    .clk     (clk),
    .rst     (rst),
    .clear   (redirect),
    .load    (skidLoad),
    .pop     (skidPop),
    .instrIn (imem.imemData),
    .pcIn    (pcPlus2),
    .full    (skidFull),
    .instr   (skidInstr),
    .pc      (skidPc)
  );

  // Sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (errSet) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

  // Fetch FSM, PC, memory request and decode output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_REQ;
      pc            <= RESET_PC;
      discard       <= 1'b0;
      waitCnt       <= {CNT_W{1'b0}};
      imem.imemEn   <= 1'b0;
      imem.imemAddr <= RESET_PC;
      instrOut      <= NOP_INSTR;
      nextPcOut     <= RESET_PC;
      validOut      <= 1'b0;
      halted        <= 1'b0;
    end else if (redirect) begin
      pc       <= {redirectPc[15:1], 1'b0};
      instrOut <= NOP_INSTR;
      validOut <= 1'b0;
      halted   <= 1'b0;
      // An outstanding request must still complete; its data is thrown away.
      if ((state == ST_WAIT) && !imem.imemDone) begin
        discard <= 1'b1;
        state   <= ST_WAIT;
      end else begin
        discard     <= 1'b0;
        state       <= ST_REQ;
        imem.imemEn <= 1'b0;
      end
    end else begin
      if (!stall) begin
        if (skidFull) begin
          instrOut  <= skidInstr;
          nextPcOut <= skidPc;
          validOut  <= 1'b1;
        end else if (freshResp) begin
          instrOut  <= imem.imemData;
          nextPcOut <= pcPlus2;
          validOut  <= 1'b1;
        end else begin
          instrOut <= NOP_INSTR;
          validOut <= 1'b0;
        end
      end

      case (state)
        ST_REQ: begin
          // Hold off while the skid entry is occupied so nothing is lost.
          if (!skidFull) begin
            imem.imemEn   <= 1'b1;
            imem.imemAddr <= pc;
            waitCnt       <= {CNT_W{1'b0}};
            state         <= ST_WAIT;
          end else begin
            imem.imemEn <= 1'b0;
            state       <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem.imemDone) begin
            imem.imemEn <= 1'b0;
            if (discard) begin
              discard <= 1'b0;
              state   <= ST_REQ;
            end else begin
              pc <= pcPlus2;
              if (isHalt(imem.imemData)) begin
                state  <= ST_HALTED;
                halted <= 1'b1;
              end else begin
                state <= ST_REQ;
              end
            end
          end else if (waitCnt != CNT_MAX) begin
            waitCnt <= waitCnt + CNT_W'(1);
          end else begin
            waitCnt <= waitCnt;
          end
        end
        ST_HALTED: begin
          imem.imemEn <= 1'b0;
        end
        default: begin
          state       <= ST_REQ;
          imem.imemEn <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a stream-level model
// of the instruction sequence decode should receive.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirectPc;
  logic [15:0] instrOut;
  logic [15:0] nextPcOut;
  logic        validOut;
  logic        halted;
  logic        err;

  fetch_stage_if imem();

  fetch_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800),
    .MAX_WAIT  (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .imem       (imem),
    .instrOut   (instrOut),
    .nextPcOut  (nextPcOut),
    .validOut   (validOut),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] mem [0:255];
  logic [15:0] haltAddr;
  int          lat;
  bit          randLat;
  bit          reqActive;
  bit          dropNext;
  bit          mHalted;
  bit          newReq;
  logic [15:0] reqAddr;
  logic [15:0] expAddr;
  int          reqCnt;
  int          reqCount;
  int          consumed;
  int          sizeBefore;
  logic [31:0] expQ [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (a == haltAddr) return 16'h0000;
    return mem[a[8:1]];
  endfunction

  task automatic resetModel();
    expQ.delete();
    reqActive = 1'b0;
    dropNext  = 1'b0;
    mHalted   = 1'b0;
    expAddr   = 16'h0000;
    reqCnt    = 0;
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_instr"},  instrOut,              16'h0800);
    chk({tag, "_nextpc"}, nextPcOut,             16'h0000);
    chk({tag, "_valid"},  {15'd0, validOut},     16'd0);
    chk({tag, "_en"},     {15'd0, imem.imemEn},  16'd0);
    chk({tag, "_addr"},   imem.imemAddr,         16'h0000);
    chk({tag, "_halted"}, {15'd0, halted},       16'd0);
    chk({tag, "_err"},    {15'd0, err},          16'd0);
  endtask

  // One clock: settle what the edge consumes, advance, then act as memory.
  task automatic tick();
    logic [31:0] front;
    logic [15:0] w;
    sizeBefore = expQ.size();
    if (!stall && validOut) begin
      consumed++;
      if (expQ.size() == 0) begin
        chk("spurious_valid", {15'd0, validOut}, 16'd0);
      end else begin
        front = expQ.pop_front();
        chk("instr", instrOut, front[31:16]);
        chk("nextpc", nextPcOut, front[15:0]);
      end
    end
    if (imem.imemEn && imem.imemDone) begin
      reqActive = 1'b0;
      if (redirect || dropNext) begin
        dropNext = 1'b0;
      end else begin
        w = memWord(reqAddr);
        expQ.push_back({w, reqAddr + 16'd2});
        if (w[15:11] == 5'b00000) mHalted = 1'b1;
      end
    end
    if (redirect) begin
      expQ.delete();
      if (imem.imemEn && !imem.imemDone) dropNext = 1'b1;
      expAddr = {redirectPc[15:1], 1'b0};
      mHalted = 1'b0;
    end
    @(posedge clk);
    #1;
    newReq = 1'b0;
    if (imem.imemEn && !reqActive) begin
      newReq = 1'b1;
      reqCount++;
      chk("req_addr", imem.imemAddr, expAddr);
      chk("req_skid_full", {15'd0, sizeBefore > 1}, 16'd0);
      reqActive = 1'b1;
      reqAddr   = imem.imemAddr;
      expAddr   = imem.imemAddr + 16'd2;
      reqCnt    = 0;
      if (randLat) lat = $urandom_range(0, 4);
    end else if (reqActive) begin
      chk("en_held", {15'd0, imem.imemEn}, 16'd1);
      chk("addr_stable", imem.imemAddr, reqAddr);
    end
    chk("halted", {15'd0, halted}, {15'd0, mHalted});
    if (mHalted) chk("en_halted", {15'd0, imem.imemEn}, 16'd0);
    imem.imemDone = reqActive && (reqCnt >= lat);
    imem.imemData = reqActive ? memWord(reqAddr) : 16'h0000;
    if (reqActive) reqCnt++;
  endtask

  task automatic waitReq(input string tag);
    int n;
    n = 0;
    newReq = 1'b0;
    while (!newReq && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {15'd0, newReq}, 16'd1);
  endtask

  initial begin
    logic [15:0] w16;
    int n;
    for (int i = 0; i < 256; i++) begin
      w16 = 16'h4000 + 16'(i * 256);
      if (w16[15:11] == 5'b00000) w16[15:11] = 5'b00010;
      mem[i] = w16;
    end
    haltAddr = 16'hFFFF;
    lat = 0; randLat = 1'b0; reqCount = 0; consumed = 0; newReq = 1'b0;
    resetModel();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = 16'h0000;
    imem.imemDone = 1'b0; imem.imemData = 16'h0000; imem.imemErr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("rst");
    rst = 1'b1;

    // Zero-wait memory: 0x4000, 0x4100, 0x4200 from addresses 0, 2, 4.
    repeat (6) tick();
    chk("zw_instr",    instrOut,          16'h4200);
    chk("zw_valid",    {15'd0, validOut}, 16'd1);
    chk("zw_nextpc",   nextPcOut,         16'h0006);
    chk("zw_consumed", 16'(consumed),     16'd2);
    chk("zw_reqs",     16'(reqCount),     16'd3);

    // Response on the third cycle of each request, stall for 4 cycles.
    lat = 2;
    repeat (4) tick();
    chk("pre_stall_instr", instrOut, 16'h4300);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_hold",  instrOut,          16'h4300);
      chk("stall_valid", {15'd0, validOut}, 16'd1);
    end
    chk("skid_full",   {15'd0, dut.skidFull}, 16'd1);
    chk("skid_no_req", {15'd0, imem.imemEn},  16'd0);
    stall = 1'b0;
    tick();
    chk("skid_pop_instr", instrOut,             16'h4400);
    chk("skid_no_req2",   {15'd0, imem.imemEn}, 16'd0);
    repeat (2) tick();

    // Redirect while a request is in flight.
    redirect = 1'b1; redirectPc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("flush_instr", instrOut,          16'h0800);
    chk("flush_valid", {15'd0, validOut}, 16'd0);
    waitReq("redir_req");
    chk("redir_addr", imem.imemAddr, 16'h0040);
    repeat (6) tick();

    // HALT fetched at 0x0006.
    haltAddr = 16'h0006; lat = 0;
    redirect = 1'b1; redirectPc = 16'h0000;
    tick();
    redirect = 1'b0;
    n = 0;
    while (!halted && n < 30) begin
      tick();
      n++;
    end
    chk("halt_reached", {15'd0, halted},   16'd1);
    chk("halt_instr",   instrOut,          16'h0000);
    chk("halt_valid",   {15'd0, validOut}, 16'd1);
    repeat (5) tick();
    chk("halt_en",     {15'd0, imem.imemEn}, 16'd0);
    chk("halt_bubble", {15'd0, validOut},    16'd0);
    redirect = 1'b1; redirectPc = 16'h0010;
    tick();
    redirect = 1'b0;
    chk("resume_halted", {15'd0, halted}, 16'd0);
    waitReq("resume_req");
    chk("resume_addr", imem.imemAddr, 16'h0010);
    haltAddr = 16'hFFFF;

    // Random stalls, latencies and aligned redirects.
    randLat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall      = ($urandom_range(0, 3) == 0);
      redirect   = ($urandom_range(0, 39) == 0);
      redirectPc = {7'd0, 8'($urandom_range(0, 255)), 1'b0};
      tick();
    end
    stall = 1'b0; redirect = 1'b0; randLat = 1'b0; lat = 0;
    repeat (8) tick();
    chk("no_err_yet", {15'd0, err}, 16'd0);

    // Misaligned redirect target.
    redirect = 1'b1; redirectPc = 16'h0013;
    tick();
    redirect = 1'b0;
    chk("mis_err", {15'd0, err}, 16'd1);
    waitReq("mis_req");
    chk("mis_addr", imem.imemAddr, 16'h0012);
    repeat (4) tick();

    // Asynchronous reset mid-cycle, then a memory that never answers.
    #2 rst = 1'b0;
    #1;
    checkReset("rst2");
    resetModel();
    imem.imemDone = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    lat = 1000;
    waitReq("to_req");
    repeat (14) tick();
    chk("to_err_early", {15'd0, err}, 16'd0);
    tick();
    chk("to_err", {15'd0, err}, 16'd1);
    repeat (5) tick();
    chk("to_err_hold", {15'd0, err}, 16'd1);
    lat = 0;
    repeat (6) tick();
    chk("to_err_sticky", {15'd0, err}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage 16-bit pipeline. It is the producer end of the fetch/decode interface.
- Owns the PC and issues requests to a variable-latency instruction memory. It drives the instruction and PC+2 into the decode stage's pipeline register.
- Handles three control inputs: hazard-unit stalls, branch/jump redirects from execute, and HALT freeze.

Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- NOP_INSTR, 16'h0800: encoding injected on flush or bubble (opcode 5'b00001).
- MAX_WAIT, 15: memory wait cycles allowed before a timeout error is raised.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- stall  in  1  hazard unit: hold instrOut/nextPcOut/validOut.
- redirect  in  1  branch/jump taken; load redirectPc and flush.
- redirectPc  in  16  target PC.
- imemEn  out  1  request strobe; held high while a request is outstanding.
- imemAddr  out  16  request address; stable while imemEn=1.
- imemDone  in  1  response valid this cycle.
- imemData  in  16  fetched instruction; sampled when imemDone=1.
- imemErr  in  1  memory error; sampled when imemDone=1.
- instrOut  out  16  instruction to decode.
- nextPcOut  out  16  PC+2 of instrOut.
- validOut  out  1  instrOut is a real instruction, not a bubble.
- halted  out  1  fetch frozen after HALT.
- err  out  1  sticky error.

Behaviour:
- Reset (rst=0, async): every register is cleared as follows.
  - pc=RESET_PC.
  - State=REQ.
  - instrOut=NOP_INSTR, nextPcOut=RESET_PC, validOut=0.
  - imemEn=0, imemAddr=RESET_PC.
  - halted=0, err=0.
  - Skid buffer empty, discard flag clear, wait counter=0.
- States:
  - REQ: drive imemEn=1, imemAddr=pc, go to WAIT.
  - WAIT: hold imemEn/imemAddr until imemDone.
  - HALTED: imemEn=0.
- WAIT on imemDone=1 with discard clear:
  - pc<=pc+2 (16-bit wrap: 16'hFFFE -> 16'h0000).
  - Instruction goes to the output register when stall=0, otherwise to the one-entry skid buffer.
  - Next state is REQ, or HALTED if imemData[15:11]==5'b00000.
- A new request is never issued while the skid buffer is full.
  - Minimum throughput: one instruction per 2 cycles with zero-wait memory. imemDone may arrive the same cycle as imemEn.
- Output register update when stall=0:
  - Load from the skid buffer if it is full (buffer empties), else from a fresh response.
  - If neither is available: instrOut=NOP_INSTR, validOut=0, nextPcOut unchanged.
- stall=1: output register and nextPcOut hold exactly.
- redirect=1: highest priority after reset, overrides stall.
  - pc<=redirectPc; output register <= NOP_INSTR, validOut=0; skid buffer cleared; halted cleared.
  - If a request is outstanding: set the discard flag and stay in WAIT. The next imemDone is dropped and the discard flag clears. Then go to REQ with the new pc.
  - Otherwise go directly to REQ.
  - Redirect arriving in the same cycle as imemDone: the response is dropped, the discard flag is not set, and the next state is REQ.
- redirectPc[0]=1: err<=1 and pc<=redirectPc with bit 0 cleared.
- HALT:
  - The HALT instruction itself is delivered with validOut=1.
  - Afterwards, bubbles until redirect. halted=1 while in HALTED.
- err (sticky until reset) is set by any of:
  - imemErr=1 with imemDone=1; the instruction is still delivered.
  - Wait counter reaching MAX_WAIT in WAIT; the counter resets per request.
  - Misaligned redirect.

Decomposition:
- Shared package:
  - Opcode constants OP_HALT=5'b00000 and OP_NOP=5'b00001.
  - Default NOP encoding.
  - Fetch state encoding: REQ, WAIT, HALTED.
- One natural sub-module: fetch_skid_buf, a one-entry instruction+PC holding register with full flag, load, pop and clear.

Test Plan:
- Reset, then zero-wait memory returning 16'h4000, 16'h4100, 16'h4200.
  - imemAddr sequence 0, 2, 4.
  - instrOut matches with validOut=1; nextPcOut = 2, 4, 6.
- Memory with 3-cycle latency and stall=1 for 4 cycles mid-stream.
  - instrOut holds; the skid buffer captures exactly one instruction.
  - No request is issued while the buffer is full; no instruction is lost or duplicated after stall drops.
- redirect=1 with redirectPc=16'h0040 while in WAIT.
  - The in-flight response is discarded; the next imemAddr is 16'h0040.
  - instrOut=16'h0800 with validOut=0 for the flush cycle.
- Fetch of 16'h0000 at pc=16'h0006.
  - HALT is delivered with validOut=1, then halted=1 and imemEn=0.
  - redirect to 16'h0010 resumes fetching at 16'h0010.
- imemDone withheld for 15 cycles: err=1 and stays 1.
- Misaligned redirectPc=16'h0013: err=1 and imemAddr=16'h0012.
